// File: rtl/stack_param.sv
// stack_param: parametrised LIFO stack with push/pop strobes, same-cycle
// replace-top, occupancy count, sticky overflow/underflow flags and a
// synchronous flush. Top of stack and status flags are combinational from
// the occupancy count, so a pushed word is visible on the next cycle.
module stack_param #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         clear_err,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Storage is deliberately not reset; only entries below count are ever read.
    logic [DATA_W-1:0] storage [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_w, empty_w;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] push_idx;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    // Occupancy decode and the two candidate storage indices.
    always_comb begin
        full_w   = (count_q == CNT_W'(DEPTH));
        empty_w  = (count_q == '0);
        // Held at 0 when empty so no index at or beyond DEPTH is ever formed.
        top_idx  = empty_w ? '0 : PTR_W'(count_q - CNT_W'(1));
        // Only used when not full, so count_q < DEPTH and the cast is lossless.
        push_idx = PTR_W'(count_q);
    end

    // Next-state: flush beats everything, then enable gates push/pop.
    // A new error in the same cycle as clear_err wins over the clear.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q & ~clear_err;
        underflow_d = underflow_q & ~clear_err;
        wr_en       = 1'b0;
        wr_idx      = push_idx;
        if (flush) begin
            count_d = '0;
        end else if (enable) begin
            case ({push, pop})
                2'b10: begin
                    if (!full_w) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty_w) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                2'b11: begin
                    // Replace top when occupied (legal even when full);
                    // on an empty stack this degenerates to a plain push.
                    wr_en = 1'b1;
                    if (!empty_w) begin
                        wr_idx = top_idx;
                    end else begin
                        count_d = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write port; suppressed while reset is held so a pending push is aborted.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            storage[wr_idx] <= data_in;
        end
    end

    // Outputs are combinational from count and storage.
    always_comb begin
        count     = count_q;
        full      = full_w;
        empty     = empty_w;
        overflow  = overflow_q;
        underflow = underflow_q;
        data_out  = empty_w ? '0 : storage[top_idx];
    end

endmodule

// File: tb/tb_stack_param.sv
// Testbench for stack_param: table-driven vectors on an 8 x 4-bit stack,
// plus hand-written sequences for async reset and a 5 x 16-bit stack.
module tb_stack_param;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic        enable, push, pop, flush, clear_err;
    logic [15:0] din;

    logic [3:0]  data_out_a;
    logic [3:0]  count_a;
    logic        full_a, empty_a, overflow_a, underflow_a;

    logic [15:0] data_out_b;
    logic [2:0]  count_b;
    logic        full_b, empty_b, overflow_b, underflow_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en, p, o, f, c;
        logic [15:0] d;
        logic [15:0] dout;
        int          cnt;
        logic        fl, em, ov, un;
    } vec_t;

    vec_t vecs[$];

    stack_param #(.DATA_W(4), .DEPTH(8)) dut_a (
        .clk(clk), .reset(reset_a), .enable(enable), .push(push), .pop(pop),
        .flush(flush), .clear_err(clear_err), .data_in(din[3:0]),
        .data_out(data_out_a), .count(count_a), .full(full_a), .empty(empty_a),
        .overflow(overflow_a), .underflow(underflow_a)
    );

    stack_param #(.DATA_W(16), .DEPTH(5)) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable), .push(push), .pop(pop),
        .flush(flush), .clear_err(clear_err), .data_in(din),
        .data_out(data_out_b), .count(count_b), .full(full_b), .empty(empty_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic p, input logic o, input logic f,
                         input logic c, input logic [15:0] d);
        enable = e; push = p; pop = o; flush = f; clear_err = c; din = d;
    endtask

    task automatic add(input logic e, input logic p, input logic o, input logic f,
                       input logic c, input logic [15:0] d, input logic [15:0] dout,
                       input int cnt, input logic fl, input logic em,
                       input logic ov, input logic un);
        vec_t v;
        v.en = e; v.p = p; v.o = o; v.f = f; v.c = c; v.d = d;
        v.dout = dout; v.cnt = cnt; v.fl = fl; v.em = em; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    task automatic check_a(input string tag, input logic [15:0] dout, input int cnt,
                           input logic fl, input logic em, input logic ov, input logic un);
        check({tag, "_dout"},  {28'd0, data_out_a}, {16'd0, dout});
        check({tag, "_count"}, {28'd0, count_a}, cnt);
        check({tag, "_full"},  {31'd0, full_a}, {31'd0, fl});
        check({tag, "_empty"}, {31'd0, empty_a}, {31'd0, em});
        check({tag, "_ovf"},   {31'd0, overflow_a}, {31'd0, ov});
        check({tag, "_unf"},   {31'd0, underflow_a}, {31'd0, un});
    endtask

    task automatic check_b(input string tag, input logic [15:0] dout, input int cnt,
                           input logic fl, input logic em, input logic ov, input logic un);
        check({tag, "_dout"},  {16'd0, data_out_b}, {16'd0, dout});
        check({tag, "_count"}, {29'd0, count_b}, cnt);
        check({tag, "_full"},  {31'd0, full_b}, {31'd0, fl});
        check({tag, "_empty"}, {31'd0, empty_b}, {31'd0, em});
        check({tag, "_ovf"},   {31'd0, overflow_b}, {31'd0, ov});
        check({tag, "_unf"},   {31'd0, underflow_b}, {31'd0, un});
    endtask

    // Apply the current inputs across one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table for the 8 x 4 stack ----------------
        for (int i = 1; i <= 8; i++)
            add(1, 1, 0, 0, 0, 16'(i), 16'(i), i, i == 8, 0, 0, 0);
        add(1, 1, 0, 0, 0, 16'hF, 16'd8, 8, 1, 0, 1, 0);   // push when full
        add(1, 0, 0, 0, 1, 16'h0, 16'd8, 8, 1, 0, 0, 0);   // clear overflow
        for (int i = 7; i >= 0; i--)
            add(1, 0, 1, 0, 0, 16'h0, 16'(i), i, 0, i == 0, 0, 0);
        add(1, 0, 1, 0, 0, 16'h0, 16'd0, 0, 0, 1, 0, 1);   // pop when empty
        add(1, 0, 1, 0, 1, 16'h0, 16'd0, 0, 0, 1, 0, 1);   // new error beats clear
        add(1, 0, 0, 0, 1, 16'h0, 16'd0, 0, 0, 1, 0, 0);   // clear underflow
        add(1, 1, 0, 0, 0, 16'h3, 16'd3, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 16'h5, 16'd5, 2, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 16'h9, 16'd9, 2, 0, 0, 0, 0);   // replace top
        add(1, 0, 1, 0, 0, 16'h0, 16'd3, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 16'h0, 16'd0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 16'h6, 16'd6, 1, 0, 0, 0, 0);   // push+pop on empty
        add(1, 1, 0, 0, 0, 16'h2, 16'd2, 2, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 16'h3, 16'd3, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 16'h7, 16'd3, 3, 0, 0, 0, 0);   // disabled push
        add(0, 0, 1, 0, 0, 16'h0, 16'd3, 3, 0, 0, 0, 0);   // disabled pop
        add(0, 1, 0, 1, 0, 16'h4, 16'd0, 0, 0, 1, 0, 0);   // flush while disabled
        add(1, 0, 1, 0, 0, 16'h0, 16'd0, 0, 0, 1, 0, 1);   // underflow
        add(1, 0, 1, 1, 0, 16'h0, 16'd0, 0, 0, 1, 0, 1);   // flush leaves flag alone
        add(0, 0, 1, 0, 1, 16'h0, 16'd0, 0, 0, 1, 0, 0);   // clear while disabled

        // ---------------- reset state ----------------
        reset_a = 1'b0; reset_b = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0);
        #12;
        check_a("rst_a", 16'h0, 0, 0, 1, 0, 0);
        check_b("rst_b", 16'h0, 0, 0, 1, 0, 0);
        reset_a = 1'b1;

        // ---------------- table run ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].p, vecs[i].o, vecs[i].f, vecs[i].c, vecs[i].d);
            step();
            $display("vec %0d en=%0b push=%0b pop=%0b flush=%0b clr=%0b din=%0h -> dout=%0h count=%0d",
                     i, vecs[i].en, vecs[i].p, vecs[i].o, vecs[i].f, vecs[i].c, vecs[i].d,
                     data_out_a, count_a);
            check_a($sformatf("v%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].fl,
                    vecs[i].em, vecs[i].ov, vecs[i].un);
        end

        // ---------------- async reset mid-cycle, 8 x 4 ----------------
        drive(1, 0, 1, 0, 0, 16'h0);
        step();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 1, 0, 0, 0, 16'(i));
            step();
        end
        check_a("a_pre_rst", 16'h5, 5, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 16'h0);
        reset_a = 1'b0;
        #2;
        $display("async reset A: count=%0d dout=%0h", count_a, data_out_a);
        check_a("a_async_rst", 16'h0, 0, 0, 1, 0, 0);
        reset_a = 1'b1;
        drive(1, 1, 0, 0, 0, 16'hA);
        step();
        check_a("a_post_rst", 16'hA, 1, 0, 0, 0, 0);

        // ---------------- 5 x 16 stack ----------------
        drive(0, 0, 0, 0, 0, 16'h0);
        reset_a = 1'b0;
        reset_b = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 1, 0, 0, 0, 16'h1000 + 16'(i));
            step();
            $display("B push %0h -> count=%0d full=%0b", din, count_b, full_b);
            check_b($sformatf("b_push%0d", i), 16'h1000 + 16'(i), i, i == 5, 0, 0, 0);
        end
        drive(1, 1, 0, 0, 1, 16'h2222);
        step();
        check_b("b_ovf_clr", 16'h1005, 5, 1, 0, 1, 0);
        drive(1, 1, 1, 0, 0, 16'hBEEF);
        step();
        check_b("b_replace_full", 16'hBEEF, 5, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 16'h0);
        step();
        check_b("b_clr", 16'hBEEF, 5, 1, 0, 0, 0);
        for (int k = 4; k >= 0; k--) begin
            drive(1, 0, 1, 0, 0, 16'h0);
            step();
            $display("B pop -> dout=%0h count=%0d", data_out_b, count_b);
            check_b($sformatf("b_pop%0d", k), (k > 0) ? 16'h1000 + 16'(k) : 16'h0, k, 0, k == 0, 0, 0);
        end
        drive(1, 0, 1, 0, 0, 16'h0);
        step();
        check_b("b_unf", 16'h0, 0, 0, 1, 0, 1);
        drive(1, 0, 1, 0, 1, 16'h0);
        step();
        check_b("b_unf_clr", 16'h0, 0, 0, 1, 0, 1);
        drive(1, 1, 0, 0, 0, 16'hABCD);
        step();
        check_b("b_push_abcd", 16'hABCD, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 16'h0);
        reset_b = 1'b0;
        #2;
        $display("async reset B: count=%0d dout=%0h", count_b, data_out_b);
        check_b("b_async_rst", 16'h0, 0, 0, 1, 0, 0);
        reset_b = 1'b1;
        drive(1, 1, 0, 0, 0, 16'h000A);
        step();
        check_b("b_post_rst", 16'h000A, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
